// File: rtl/ipg_pkg.sv
// Shared codes, state encoding and default widths for the IPG request/response engine.
package ipg_pkg;

    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_HDR_W     = 8;
    localparam int unsigned DEF_ADDR_W    = 64;
    localparam int unsigned DEF_PAYLOAD_W = 512;
    localparam int unsigned DEF_MEM_DEPTH = 8;

    localparam logic [7:0] READ_REQ  = 8'h00;
    localparam logic [7:0] WRITE_REQ = 8'h01;
    localparam logic [7:0] READ_RESP = 8'h02;
    localparam logic [7:0] WRITE_ACK = 8'h03;

    typedef enum logic [1:0] {
        StHdr,
        StAddr,
        StData,
        StResp
    } ipg_state_e;

endpackage

// File: rtl/ipg_req_engine_if.sv
// RX chunk stream and buffered reply handshake between the IPG extractor, engine and TX queue.
interface ipg_req_engine_if
    import ipg_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned LEN_W   = $clog2(DEF_DATA_W) + 1,
    parameter int unsigned REPLY_W = DEF_HDR_W + DEF_PAYLOAD_W
);
    logic [DATA_W-1:0]  rx_ipg_data;
    logic [LEN_W-1:0]   rx_len;
    logic [REPLY_W-1:0] reply_data;
    logic               reply_valid;
    logic               reply_ready;

    modport master (
        output rx_ipg_data, rx_len, reply_ready,
        input  reply_data, reply_valid
    );

    modport slave (
        input  rx_ipg_data, rx_len, reply_ready,
        output reply_data, reply_valid
    );

endinterface

// File: rtl/ipg_field_shifter.sv
// Inserts the top `take` bits of a chunk into a field at [rem-1 -: take] and returns the
// unconsumed part of the chunk, left-justified.
module ipg_field_shifter
    import ipg_pkg::*;
#(
    parameter int unsigned FIELD_W = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned REM_W   = 10,
    parameter int unsigned LEN_W   = 7
) (
    input  logic [FIELD_W-1:0] field,
    input  logic [REM_W-1:0]   rem,
    input  logic [DATA_W-1:0]  chunk,
    input  logic [LEN_W-1:0]   take,
    output logic [FIELD_W-1:0] field_out,
    output logic [DATA_W-1:0]  leftover
);
    localparam int unsigned W = (FIELD_W > DATA_W) ? FIELD_W : DATA_W;

    logic [W-1:0] ones, bits, mask, placed;
    logic [31:0]  low;

    always_comb begin
        ones      = '1;
        low       = 32'(rem) - 32'(take);
        // A shift by the full width yields zero, which covers take == 0.
        bits      = W'(chunk >> (DATA_W - 32'(take)));
        mask      = (ones >> (W - 32'(take))) << low;
        placed    = bits << low;
        field_out = FIELD_W'((W'(field) & ~mask) | (placed & mask));
        leftover  = chunk << take;
    end

endmodule

// File: rtl/ipg_req_engine.sv
// Parses MSB-first IPG chunks into header/address/payload, serves reads and writes against a
// small register memory, and buffers one reply for the TX queue.
module ipg_req_engine
    import ipg_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned HDR_W      = DEF_HDR_W,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned PAYLOAD_W  = DEF_PAYLOAD_W,
    parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int unsigned ACK_WRITES = 1,
    parameter int unsigned LEN_W      = $clog2(DATA_W) + 1
) (
    input  logic            clk,
    input  logic            rst,
    ipg_req_engine_if.slave bus,
    output logic            busy,
    output logic [15:0]     err_count,
    output logic [15:0]     drop_count
);
    localparam int unsigned REM_W = $clog2(PAYLOAD_W + 1);
    localparam int unsigned IDX   = $clog2(MEM_DEPTH);

    ipg_state_e                 state_q;
    logic [REM_W-1:0]           rem_q;
    logic [HDR_W-1:0]           hdr_q;
    logic [ADDR_W-1:0]          addr_q;
    logic [PAYLOAD_W-1:0]       pay_q;
    logic                       op_wr_q;
    logic [PAYLOAD_W-1:0]       mem_q [MEM_DEPTH];
    logic [HDR_W+PAYLOAD_W-1:0] reply_q;
    logic                       reply_valid_q;
    logic [15:0]                err_q, drop_q;

    logic [LEN_W-1:0]     len_eff, take1, left1;
    logic [REM_W-1:0]     rem_after, addr_rem, pay_rem;
    logic [LEN_W-1:0]     hdr_take, addr_take, pay_take;
    logic [DATA_W-1:0]    hdr_left, addr_left, addr_chunk, pay_chunk, unused_pay_left;
    logic [HDR_W-1:0]     hdr_new;
    logic [ADDR_W-1:0]    addr_new;
    logic [PAYLOAD_W-1:0] pay_new;
    logic                 hdr_done, hdr_ok, addr_done, pay_done, reply_load;

    assign len_eff    = (rx_len_gt()) ? LEN_W'(DATA_W) : bus.rx_len;
    assign take1      = (REM_W'(len_eff) > rem_q) ? LEN_W'(rem_q) : len_eff;
    assign left1      = len_eff - take1;
    assign rem_after  = rem_q - REM_W'(take1);
    assign hdr_take   = (state_q == StHdr) ? take1 : '0;
    assign addr_chunk = (state_q == StHdr) ? hdr_left : bus.rx_ipg_data;
    assign pay_chunk  = (state_q == StAddr) ? addr_left : bus.rx_ipg_data;
    assign hdr_done   = (state_q == StHdr) && (rem_after == '0);
    assign addr_done  = (state_q == StAddr) && (rem_after == '0);
    assign pay_done   = (state_q == StData) && (rem_after == '0);
    assign hdr_ok     = hdr_done && ((hdr_new == HDR_W'(READ_REQ)) ||
                                     (hdr_new == HDR_W'(WRITE_REQ)));
    assign reply_load = !reply_valid_q || bus.reply_ready;

    function automatic logic rx_len_gt();
        return 32'(bus.rx_len) > DATA_W;
    endfunction

    // Leftover bits spill into the next field only across HDR->ADDR and ADDR->DATA.
    always_comb begin
        addr_take = '0;
        addr_rem  = REM_W'(ADDR_W);
        pay_take  = '0;
        pay_rem   = REM_W'(PAYLOAD_W);
        unique case (state_q)
            StHdr:  if (hdr_ok) addr_take = left1;
            StAddr: begin
                addr_take = take1;
                addr_rem  = rem_q;
                if (addr_done && op_wr_q) pay_take = left1;
            end
            StData: begin
                pay_take = take1;
                pay_rem  = rem_q;
            end
            default: ;
        endcase
    end

    ipg_field_shifter #(.FIELD_W(HDR_W), .DATA_W(DATA_W), .REM_W(REM_W), .LEN_W(LEN_W)) u_hdr (
        .field(hdr_q), .rem(rem_q), .chunk(bus.rx_ipg_data), .take(hdr_take),
        .field_out(hdr_new), .leftover(hdr_left)
    );

    ipg_field_shifter #(.FIELD_W(ADDR_W), .DATA_W(DATA_W), .REM_W(REM_W), .LEN_W(LEN_W)) u_addr (
        .field(addr_q), .rem(addr_rem), .chunk(addr_chunk), .take(addr_take),
        .field_out(addr_new), .leftover(addr_left)
    );

    ipg_field_shifter #(.FIELD_W(PAYLOAD_W), .DATA_W(DATA_W), .REM_W(REM_W), .LEN_W(LEN_W))
    u_pay (
        .field(pay_q), .rem(pay_rem), .chunk(pay_chunk), .take(pay_take),
        .field_out(pay_new), .leftover(unused_pay_left)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StHdr;
            rem_q         <= REM_W'(HDR_W);
            hdr_q         <= '0;
            addr_q        <= '0;
            pay_q         <= '0;
            op_wr_q       <= 1'b0;
            reply_q       <= '0;
            reply_valid_q <= 1'b0;
            err_q         <= '0;
            drop_q        <= '0;
            for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            hdr_q  <= hdr_new;
            addr_q <= addr_new;
            pay_q  <= pay_new;
            if (reply_valid_q && bus.reply_ready) reply_valid_q <= 1'b0;
            unique case (state_q)
                StHdr: begin
                    if (hdr_ok) begin
                        op_wr_q <= (hdr_new == HDR_W'(WRITE_REQ));
                        rem_q   <= REM_W'(ADDR_W) - REM_W'(left1);
                        state_q <= StAddr;
                    end else if (hdr_done) begin
                        rem_q <= REM_W'(HDR_W);
                        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                    end else begin
                        rem_q <= rem_after;
                    end
                end
                StAddr: begin
                    if (addr_done && op_wr_q) begin
                        rem_q   <= REM_W'(PAYLOAD_W) - REM_W'(left1);
                        state_q <= StData;
                    end else if (addr_done) begin
                        rem_q   <= REM_W'(HDR_W);
                        state_q <= StResp;
                    end else begin
                        rem_q <= rem_after;
                    end
                end
                StData: begin
                    if (pay_done) begin
                        mem_q[addr_q[IDX-1:0]] <= pay_new;
                        rem_q                  <= REM_W'(HDR_W);
                        state_q                <= (ACK_WRITES != 0) ? StResp : StHdr;
                    end else begin
                        rem_q <= rem_after;
                    end
                end
                StResp: begin
                    if (reply_load) begin
                        reply_valid_q <= 1'b1;
                        reply_q       <= op_wr_q ? {HDR_W'(WRITE_ACK), {PAYLOAD_W{1'b0}}}
                                                 : {HDR_W'(READ_RESP), mem_q[addr_q[IDX-1:0]]};
                    end else if (drop_q != 16'hFFFF) begin
                        drop_q <= drop_q + 16'd1;
                    end
                    if (bus.rx_len != '0 && err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                    state_q <= StHdr;
                end
                default: state_q <= StHdr;
            endcase
        end
    end

    assign bus.reply_data  = reply_q;
    assign bus.reply_valid = reply_valid_q;
    assign busy            = (state_q != StHdr) || (rem_q != REM_W'(HDR_W));
    assign err_count       = err_q;
    assign drop_count      = drop_q;

endmodule

// File: tb/tb_ipg_req_engine.sv
// Directed bench for ipg_req_engine: split reads, write/read-back, bad headers,
// reply backpressure, illegal RESP input and asynchronous reset mid-message.
module tb_ipg_req_engine;
    import ipg_pkg::*;

    localparam int DW = 64;
    localparam int LW = 7;
    localparam int PW = 512;
    localparam int RW = 8 + PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [15:0]   err_count;
    logic [15:0]   drop_count;
    logic [PW-1:0] pat;
    logic [PW-1:0] zero_pl;
    int            total = 0;
    int            bad = 0;

    ipg_req_engine_if #(.DATA_W(DW), .LEN_W(LW), .REPLY_W(RW)) bus ();

    ipg_req_engine #(
        .DATA_W(DW), .HDR_W(8), .ADDR_W(64), .PAYLOAD_W(PW), .MEM_DEPTH(8),
        .ACK_WRITES(1), .LEN_W(LW)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy),
        .err_count(err_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [63:0] d, input int len);
        bus.rx_ipg_data = d;
        bus.rx_len      = LW'(len);
        @(posedge clk);
        #1;
    endtask

    task automatic send_read(input logic [63:0] addr);
        step({8'h00, addr[63:8]}, 64);
        step({addr[7:0], 56'h12_3456_789A_BCDE}, 64);
    endtask

    task automatic send_write(input logic [63:0] addr, input logic [PW-1:0] pl);
        logic [639:0] s;
        s = {8'h01, addr, pl, 56'h0};
        for (int i = 0; i < 10; i++) step(s[639-64*i -: 64], 64);
    endtask

    task automatic test_reset;
        total++;
        if (bus.reply_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid: got %b want 0", bus.reply_valid);
        end
        total++;
        if (bus.reply_data !== {8'h00, zero_pl}) begin
            bad++; $display("FAIL rst_data: got %h want 0", bus.reply_data);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++;
        if (err_count !== 16'd0) begin
            bad++; $display("FAIL rst_err: got %0d want 0", err_count);
        end
        total++;
        if (drop_count !== 16'd0) begin
            bad++; $display("FAIL rst_drop: got %0d want 0", drop_count);
        end
    endtask

    task automatic test_read_split;
        step({8'h00, 32'h0, 24'hAB_CDEF}, 40);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL split_busy: got %b want 1", busy); end
        step({32'h5, 32'hDEAD_BEEF}, 32);
        total++;
        if (bus.reply_valid !== 1'b0) begin
            bad++; $display("FAIL split_early: got %b want 0", bus.reply_valid);
        end
        step(64'h0, 0);
        total++;
        if (bus.reply_valid !== 1'b1) begin
            bad++; $display("FAIL split_valid: got %b want 1", bus.reply_valid);
        end
        total++;
        if (bus.reply_data !== {READ_RESP, zero_pl}) begin
            bad++; $display("FAIL split_data: got %h want %h", bus.reply_data, {READ_RESP, zero_pl});
        end
        step(64'h0, 0);
        total++;
        if (bus.reply_valid !== 1'b0) begin
            bad++; $display("FAIL split_accept: got %b want 0", bus.reply_valid);
        end
    endtask

    task automatic test_write_read;
        send_write(64'h3, pat);
        total++;
        if (bus.reply_valid !== 1'b0) begin
            bad++; $display("FAIL wr_early: got %b want 0", bus.reply_valid);
        end
        step(64'h0, 0);
        total++;
        if (bus.reply_valid !== 1'b1 || bus.reply_data !== {WRITE_ACK, zero_pl}) begin
            bad++; $display("FAIL wr_ack: got %b/%h want 1/%h", bus.reply_valid, bus.reply_data,
                            {WRITE_ACK, zero_pl});
        end
        send_read(64'h13);
        step(64'h0, 0);
        total++;
        if (bus.reply_valid !== 1'b1 || bus.reply_data !== {READ_RESP, pat}) begin
            bad++; $display("FAIL wr_readback: got %b/%h want 1/%h", bus.reply_valid,
                            bus.reply_data, {READ_RESP, pat});
        end
    endtask

    task automatic test_bad_header;
        step({8'h7F, 56'h00_0000_0000_0003}, 64);
        total++;
        if (err_count !== 16'd1) begin
            bad++; $display("FAIL bad_err: got %0d want 1", err_count);
        end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL bad_busy: got %b want 0", busy); end
        total++;
        if (bus.reply_valid !== 1'b0) begin
            bad++; $display("FAIL bad_noreply: got %b want 0", bus.reply_valid);
        end
        send_read(64'h3);
        step(64'h0, 0);
        total++;
        if (bus.reply_valid !== 1'b1 || bus.reply_data !== {READ_RESP, pat}) begin
            bad++; $display("FAIL bad_next: got %b/%h want 1/%h", bus.reply_valid,
                            bus.reply_data, {READ_RESP, pat});
        end
    endtask

    task automatic test_backpressure;
        step(64'h0, 0);
        bus.reply_ready = 1'b0;
        send_read(64'h3);
        step(64'h0, 0);
        send_read(64'h5);
        total++;
        if (bus.reply_valid !== 1'b1 || bus.reply_data !== {READ_RESP, pat}) begin
            bad++; $display("FAIL bp_hold: got %b/%h want 1/%h", bus.reply_valid,
                            bus.reply_data, {READ_RESP, pat});
        end
        step(64'h0, 0);
        total++;
        if (drop_count !== 16'd1) begin
            bad++; $display("FAIL bp_drop: got %0d want 1", drop_count);
        end
        total++;
        if (bus.reply_valid !== 1'b1 || bus.reply_data !== {READ_RESP, pat}) begin
            bad++; $display("FAIL bp_keep: got %b/%h want 1/%h", bus.reply_valid,
                            bus.reply_data, {READ_RESP, pat});
        end
        bus.reply_ready = 1'b1;
        step(64'h0, 0);
        total++;
        if (bus.reply_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release: got %b want 0", bus.reply_valid);
        end
    endtask

    task automatic test_illegal_resp;
        step({8'h00, 56'h0}, 64);
        step({8'h03, 56'h0}, 100);
        step({16'hFFFF, 48'h0}, 16);
        total++;
        if (err_count !== 16'd2) begin
            bad++; $display("FAIL ill_err: got %0d want 2", err_count);
        end
        total++;
        if (bus.reply_data !== {READ_RESP, pat}) begin
            bad++; $display("FAIL ill_reply: got %h want %h", bus.reply_data, {READ_RESP, pat});
        end
        send_read(64'h0);
        step(64'h0, 0);
        total++;
        if (bus.reply_valid !== 1'b1 || bus.reply_data !== {READ_RESP, zero_pl}
            || err_count !== 16'd2) begin
            bad++; $display("FAIL ill_next: got %b/%0d/%h want 1/2/%h", bus.reply_valid,
                            err_count, bus.reply_data, {READ_RESP, zero_pl});
        end
    endtask

    task automatic test_reset_mid_write;
        bus.reply_ready = 1'b0;
        step({8'h01, 56'h0}, 64);
        step({8'h06, 56'hFF_FFFF_FFFF_FFFF}, 64);
        step(64'hFFFF_FFFF_FFFF_FFFF, 44);
        total++;
        if (busy !== 1'b1 || bus.reply_valid !== 1'b1) begin
            bad++; $display("FAIL mid_busy: got %b/%b want 1/1", busy, bus.reply_valid);
        end
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        test_reset;
        bus.reply_ready = 1'b1;
        send_read(64'h6);
        step(64'h0, 0);
        total++;
        if (bus.reply_valid !== 1'b1 || bus.reply_data !== {READ_RESP, zero_pl}) begin
            bad++; $display("FAIL mid_nowrite: got %b/%h want 1/%h", bus.reply_valid,
                            bus.reply_data, {READ_RESP, zero_pl});
        end
        send_read(64'h3);
        step(64'h0, 0);
        total++;
        if (bus.reply_data !== {READ_RESP, zero_pl}) begin
            bad++; $display("FAIL mid_memclr: got %h want %h", bus.reply_data,
                            {READ_RESP, zero_pl});
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.rx_ipg_data = '0;
        bus.rx_len      = '0;
        bus.reply_ready = 1'b1;
        pat             = {8{64'hA5A5_0000_1111_2222}};
        zero_pl         = '0;
        #12 rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_read_split;
        test_write_read;
        test_bad_header;
        test_backpressure;
        test_illegal_resp;
        test_reset_mid_write;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ipg_req_engine.md
# ipg_req_engine

Parametrised request/response engine for memory messages carried in inter-packet-gap bits. It assembles an MSB-first bit stream, delivered in variable-length chunks, into header, address and payload fields, and serves reads and writes against a small internal register memory. It produces one-entry buffered replies with a valid/ready handshake, for the TX-side IPG message queue. It sits between the PHY RX IPG extractor and the IPG TX enqueue logic.

## Interface
- DATA_W, 64: chunk width (bits per rx_ipg_data word)
- HDR_W, 8: header field width; must satisfy HDR_W < DATA_W
- ADDR_W, 64: address field width; must satisfy ADDR_W >= DATA_W
- PAYLOAD_W, 512: write/read payload width; must satisfy PAYLOAD_W >= DATA_W
- MEM_DEPTH, 8: payload entries in the internal memory; power of two
- ACK_WRITES, 1: 1 means each completed write produces a WRITE_ACK reply
- LEN_W, $clog2(DATA_W)+1: rx_len width
- clk  in  1  sole clock
- rst  in  1  reset, asynchronous, active-high
- rx_ipg_data  in  DATA_W  chunk; valid bits are MSB-aligned, [DATA_W-1 -: rx_len]
- rx_len  in  LEN_W  number of valid bits this cycle; 0 means no data; values > DATA_W are treated as DATA_W
- reply_data  out  HDR_W+PAYLOAD_W  reply; code in [MSB -: HDR_W], payload below it
- reply_valid  out  1  reply_data holds an unaccepted reply
- reply_ready  in  1  consumer accepts when reply_valid && reply_ready
- busy  out  1  state != HDR or the field counter is partially filled
- err_count  out  16  saturating count of bad headers and illegal RESP-cycle input
- drop_count  out  16  saturating count of replies lost to a full reply buffer

## Operation
- States: HDR, ADDR, DATA, RESP.
- Field counter `rem` holds the bits still needed for the current field. It loads HDR_W, ADDR_W or PAYLOAD_W on entry to the corresponding field.
- Each cycle, take = min(rx_len, rem) bits from the top of the chunk. They are written MSB-first into the field at bit positions [rem-1 -: take], and rem decreases by take.
- Field completion with leftover bits (rx_len > take): the leftover bits feed the next field in the same cycle (HDR to ADDR, ADDR to DATA). At most one boundary can be crossed per cycle, which the parameter constraints guarantee.
- Leftover bits after a message's final field are discarded. Every message starts on a chunk boundary.
- HDR completes:
  - Code READ_REQ (0) or WRITE_REQ (1): go to ADDR.
  - Any other code: err_count++, discard the rest of the chunk, stay in HDR.
- ADDR completes:
  - READ: go to RESP.
  - WRITE: go to DATA.
- DATA completes: mem[addr[IDX-1:0]] <= payload, where IDX = $clog2(MEM_DEPTH).
  - ACK_WRITES=1: go to RESP.
  - ACK_WRITES=0: go to HDR.
- Address upper bits beyond IDX are ignored, so addresses wrap modulo MEM_DEPTH.
- RESP (exactly one cycle): build the reply, then return to HDR.
  - Read reply: {READ_RESP=8'h02, mem[idx]}.
  - Write reply: {WRITE_ACK=8'h03, zero payload}.
- RESP loading rules:
  - If the reply buffer is empty, or is accepted in this same cycle, load it.
  - Otherwise keep the old reply and increment drop_count.
- rx_len must be 0 during RESP. A nonzero value is discarded and err_count++.
- A write to the entry currently being read in RESP cannot occur, because only one message is in flight at a time.
- Reset clears all state, field registers, the memory and the counters.
  - Reset asserted mid-message abandons the message; nothing is written and no reply is issued.
  - Output reset values: reply_data=0, reply_valid=0, busy=0, err_count=0, drop_count=0.

## Timing
- One chunk is consumed per cycle. There is no backpressure on RX.
- If the chunk completing the address (read) or payload (write ack) is sampled at edge N, RESP occupies the cycle after edge N, and reply_valid rises after edge N+1.
- Read latency from the last address bit to reply_valid: 2 edges.
- reply_valid stays high, with reply_data stable, until the cycle after acceptance. A simultaneous accept and load in RESP keeps reply_valid high with the new data.
- The memory write takes effect at the edge that completes DATA. A read issued by the next message sees the new value.
- Both counters saturate at 16'hFFFF.

## Structure
- Package ipg_pkg holds:
  - header codes READ_REQ, WRITE_REQ, READ_RESP, WRITE_ACK;
  - the state enum;
  - the default widths.
- Sub-module ipg_field_shifter: combinational MSB-aligned bit insertion. Inputs are field, rem, chunk and take; outputs are the updated field and the leftover chunk, left-justified. It is instantiated once per field path.

## Test plan
- Read split across chunks: chunks of rx_len 40, 32, 0 carry hdr 0 and addr 64'h5. After 2 edges, reply_valid=1 with reply_data[519:512]=8'h02 and the payload equal to the reset value 0.
- Write then read: write hdr 1, addr 3, payload {8{64'hA5A5_0000_1111_2222}} in full 64-bit chunks, where addr and data straddle the same chunk. Expect WRITE_ACK 8'h03. A following read of addr 64'h13 (wraps to 3) returns the written payload.
- Bad header: hdr 8'h7F in a 64-bit chunk. Expect err_count=1, state HDR, no reply, and the next valid read served normally.
- Backpressure: hold reply_ready=0 across two reads. Expect the first reply held stable, drop_count=1, and the first reply delivered when reply_ready=1.
- Illegal RESP input: rx_len=16 during the RESP cycle. Expect err_count+1, those bits ignored, and the next message parsed correctly.
- Reset mid-write after 100 payload bits: async rst pulse. Expect all outputs at reset values, the memory unchanged from zero, and busy=0.
